// File: rtl/abus_seq_pkg.sv
// abus_seq_pkg
//   Shared types and constants for the address-bus vector sequencer:
//   sequencer state encoding, interrupt source encoding, and the
//   Z_ADL{2,1,0} zeroing patterns that select each vector address.
package abus_seq_pkg;

    typedef enum logic [2:0] {
        ST_RES_HOLD,
        ST_IDLE,
        ST_T1,          // dummy read
        ST_T2,          // push PCH
        ST_T3,          // push PCL
        ST_T4,          // push P
        ST_T5,          // vector low
        ST_T6           // vector high
    } state_e;

    typedef enum logic [1:0] {
        SRC_RES,
        SRC_NMI,
        SRC_IRQ,
        SRC_BRK
    } src_e;

    // Z_ADL{2,1,0} for the vector-low read (FFFA / FFFC / FFFE).
    // The vector-high read uses the same pattern with bit 0 released.
    localparam logic [2:0] ZPAT_NMI = 3'b101;
    localparam logic [2:0] ZPAT_RES = 3'b011;
    localparam logic [2:0] ZPAT_IRQ = 3'b001;

    function automatic logic [2:0] z_pattern(input src_e vec, input logic high_byte);
        logic [2:0] p;
        case (vec)
            SRC_NMI: p = ZPAT_NMI;
            SRC_RES: p = ZPAT_RES;
            default: p = ZPAT_IRQ;
        endcase
        if (high_byte)
            p[0] = 1'b0;
        return p;
    endfunction

endpackage

// File: rtl/nmi_edge_det.sv
// nmi_edge_det
//   Samples n_nmi on each phi0 rising edge and latches a falling edge
//   into 'pending' until 'clear' is asserted. Edges arriving while the
//   latch is already set are absorbed.
// Ports:
//   phi0    in  core clock
//   n_res   in  asynchronous active-low reset
//   n_nmi   in  NMI pin (active-low)
//   clear   in  drop the pending request on this edge
//   pending out latched NMI request
module nmi_edge_det
(
    input  logic phi0,
    input  logic n_res,
    input  logic n_nmi,
    input  logic clear,
    output logic pending
);

    logic nmi_q;

    always_ff @(posedge phi0 or negedge n_res) begin
        if (!n_res) begin
            // Sample flop starts low so a pin already held low through
            // reset is not mistaken for a fresh falling edge.
            nmi_q   <= 1'b0;
            pending <= 1'b0;
        end else begin
            nmi_q <= n_nmi;
            if (clear)
                pending <= 1'b0;
            else if (nmi_q && !n_nmi)
                pending <= 1'b1;
        end
    end

endmodule

// File: rtl/abus_vector_seq.sv
// abus_vector_seq
//   Address-bus sequencer for interrupt / reset entry. Arbitrates RES,
//   NMI, IRQ and BRK, runs the 7-cycle push + vector-fetch sequence and
//   owns the ABL/ABH load enables and Z_ADL vector strobes. In IDLE the
//   decoder's load enables pass straight through.
// Ports:
//   PHI0, n_RES               clock, async active-low reset
//   n_NMI, n_IRQ, I_FLAG      interrupt pins and P.I flag
//   BRK_REQ, SYNC, RDY        decoder strobe, instruction boundary, stall
//   DEC_ADL_ABL, DEC_ADH_ABH  decoder load-enable requests
//   ADL_ABL, ADH_ABH          address-bus load enables
//   Z_ADL0..2                 ADL bit-zeroing strobes
//   VEC_FETCH, STACK_PUSH     vector-read / push cycle flags
//   RW_SUPPRESS, B_OUT        push-to-read conversion, B bit for P push
//   SEQ_BUSY                  sequencer not idle
module abus_vector_seq
    import abus_seq_pkg::*;
(
    input  logic PHI0,
    input  logic n_RES,
    input  logic n_NMI,
    input  logic n_IRQ,
    input  logic I_FLAG,
    input  logic BRK_REQ,
    input  logic SYNC,
    input  logic RDY,
    input  logic DEC_ADL_ABL,
    input  logic DEC_ADH_ABH,
    output logic ADL_ABL,
    output logic ADH_ABH,
    output logic Z_ADL0,
    output logic Z_ADL1,
    output logic Z_ADL2,
    output logic VEC_FETCH,
    output logic STACK_PUSH,
    output logic RW_SUPPRESS,
    output logic B_OUT,
    output logic SEQ_BUSY
);

    state_e     state, state_nx;
    src_e       src, src_nx;        // source as latched at T1 (drives B_OUT)
    src_e       vec, vec_nx;        // vector actually fetched (may be hijacked)
    logic       nmi_pend;
    logic       nmi_clear;
    logic       irq_req;
    logic       seq_ld;
    logic       pass_en;
    logic [2:0] z_nx;

    nmi_edge_det u_nmi (
        .phi0    (PHI0),
        .n_res   (n_RES),
        .n_nmi   (n_NMI),
        .clear   (nmi_clear),
        .pending (nmi_pend)
    );

    assign irq_req = !n_IRQ && !I_FLAG;

    always_comb begin
        state_nx = state;
        src_nx   = src;
        vec_nx   = vec;
        case (state)
            ST_RES_HOLD: begin
                state_nx = ST_T1;
                src_nx   = SRC_RES;
                vec_nx   = SRC_RES;
            end
            ST_IDLE: begin
                if (RDY && SYNC && (nmi_pend || irq_req || BRK_REQ)) begin
                    state_nx = ST_T1;
                    if (nmi_pend)
                        src_nx = SRC_NMI;
                    else if (irq_req)
                        src_nx = SRC_IRQ;
                    else
                        src_nx = SRC_BRK;
                    vec_nx = src_nx;
                end
            end
            ST_T1:   if (RDY) state_nx = ST_T2;
            ST_T2:   state_nx = ST_T3;
            ST_T3:   state_nx = ST_T4;
            ST_T4:   state_nx = ST_T5;
            ST_T5:   if (RDY) state_nx = ST_T6;
            ST_T6:   if (RDY) state_nx = ST_IDLE;
            default: state_nx = ST_RES_HOLD;
        endcase
        // Hijack: a pending NMI seen during T1..T4 of an IRQ/BRK sequence
        // redirects the vector fetch; src (and so B_OUT) is left alone.
        if ((state inside {ST_T1, ST_T2, ST_T3, ST_T4}) && nmi_pend &&
            (src == SRC_IRQ || src == SRC_BRK))
            vec_nx = SRC_NMI;
    end

    // T4 always advances, so this is exactly "entering T5 with the NMI vector".
    assign nmi_clear = (state == ST_T4) && (vec_nx == SRC_NMI);

    assign z_nx = z_pattern(vec_nx, state_nx == ST_T6);

    // Outputs are decoded from the next state so they are registered yet
    // line up with the state they describe.
    always_ff @(posedge PHI0 or negedge n_RES) begin
        if (!n_RES) begin
            state       <= ST_RES_HOLD;
            src         <= SRC_RES;
            vec         <= SRC_RES;
            seq_ld      <= 1'b0;
            pass_en     <= 1'b0;
            Z_ADL0      <= 1'b0;
            Z_ADL1      <= 1'b0;
            Z_ADL2      <= 1'b0;
            VEC_FETCH   <= 1'b0;
            STACK_PUSH  <= 1'b0;
            RW_SUPPRESS <= 1'b1;
            B_OUT       <= 1'b0;
            SEQ_BUSY    <= 1'b1;
        end else begin
            state       <= state_nx;
            src         <= src_nx;
            vec         <= vec_nx;
            seq_ld      <= state_nx inside {ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6};
            pass_en     <= state_nx == ST_IDLE;
            {Z_ADL2, Z_ADL1, Z_ADL0} <= (state_nx inside {ST_T5, ST_T6}) ? z_nx : 3'b000;
            VEC_FETCH   <= state_nx inside {ST_T5, ST_T6};
            STACK_PUSH  <= state_nx inside {ST_T2, ST_T3, ST_T4};
            RW_SUPPRESS <= (state_nx == ST_RES_HOLD) ||
                           ((state_nx inside {ST_T2, ST_T3, ST_T4}) && src_nx == SRC_RES);
            B_OUT       <= (state_nx inside {ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6}) &&
                           src_nx == SRC_BRK;
            SEQ_BUSY    <= state_nx != ST_IDLE;
        end
    end

    // Passthrough is combinational from the decoder but gated by the
    // registered IDLE flag, so it is forced low during reset.
    assign ADL_ABL = seq_ld || (pass_en && DEC_ADL_ABL);
    assign ADH_ABH = seq_ld || (pass_en && DEC_ADH_ABH);

endmodule

// File: tb/tb_abus_vector_seq.sv
// tb_abus_vector_seq
//   Directed-vector bench for abus_vector_seq. Observed outputs are packed
//   as {SEQ_BUSY, ADL_ABL, ADH_ABH, Z_ADL2, Z_ADL1, Z_ADL0, VEC_FETCH,
//   STACK_PUSH, RW_SUPPRESS, B_OUT} and compared to hand-written constants.
module tb_abus_vector_seq;

    logic PHI0 = 1'b0;
    logic n_RES, n_NMI, n_IRQ, I_FLAG, BRK_REQ, SYNC, RDY;
    logic DEC_ADL_ABL, DEC_ADH_ABH;
    logic ADL_ABL, ADH_ABH, Z_ADL0, Z_ADL1, Z_ADL2;
    logic VEC_FETCH, STACK_PUSH, RW_SUPPRESS, B_OUT, SEQ_BUSY;
    logic [9:0] obs;

    int n_cmp = 0;
    int n_bad = 0;

    //                                  busy adl adh z2z1z0 vf sp rws b
    localparam logic [9:0] E_RST  = 10'b1_0_0_000_0_0_1_0;
    localparam logic [9:0] E_IDLE = 10'b0_0_0_000_0_0_0_0;
    localparam logic [9:0] R_T1   = 10'b1_1_1_000_0_0_0_0;
    localparam logic [9:0] R_PU   = 10'b1_1_1_000_0_1_1_0;
    localparam logic [9:0] R_T5   = 10'b1_1_1_011_1_0_0_0;
    localparam logic [9:0] R_T6   = 10'b1_1_1_010_1_0_0_0;
    localparam logic [9:0] I_T1   = 10'b1_1_1_000_0_0_0_0;
    localparam logic [9:0] I_PU   = 10'b1_1_1_000_0_1_0_0;
    localparam logic [9:0] I_T5   = 10'b1_1_1_001_1_0_0_0;
    localparam logic [9:0] I_T6   = 10'b1_1_1_000_1_0_0_0;
    localparam logic [9:0] B_T1   = 10'b1_1_1_000_0_0_0_1;
    localparam logic [9:0] B_PU   = 10'b1_1_1_000_0_1_0_1;
    localparam logic [9:0] BN_T5  = 10'b1_1_1_101_1_0_0_1;
    localparam logic [9:0] BN_T6  = 10'b1_1_1_100_1_0_0_1;
    localparam logic [9:0] N_T5   = 10'b1_1_1_101_1_0_0_0;
    localparam logic [9:0] N_T6   = 10'b1_1_1_100_1_0_0_0;

    abus_vector_seq dut (
        .PHI0        (PHI0),
        .n_RES       (n_RES),
        .n_NMI       (n_NMI),
        .n_IRQ       (n_IRQ),
        .I_FLAG      (I_FLAG),
        .BRK_REQ     (BRK_REQ),
        .SYNC        (SYNC),
        .RDY         (RDY),
        .DEC_ADL_ABL (DEC_ADL_ABL),
        .DEC_ADH_ABH (DEC_ADH_ABH),
        .ADL_ABL     (ADL_ABL),
        .ADH_ABH     (ADH_ABH),
        .Z_ADL0      (Z_ADL0),
        .Z_ADL1      (Z_ADL1),
        .Z_ADL2      (Z_ADL2),
        .VEC_FETCH   (VEC_FETCH),
        .STACK_PUSH  (STACK_PUSH),
        .RW_SUPPRESS (RW_SUPPRESS),
        .B_OUT       (B_OUT),
        .SEQ_BUSY    (SEQ_BUSY)
    );

    always #5 PHI0 = ~PHI0;

    assign obs = {SEQ_BUSY, ADL_ABL, ADH_ABH, Z_ADL2, Z_ADL1, Z_ADL0,
                  VEC_FETCH, STACK_PUSH, RW_SUPPRESS, B_OUT};

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PHI0);
        #1;
    endtask

    task automatic step(input string tag, input logic [9:0] exp);
        tick();
        check(tag, obs, exp);
    endtask

    initial begin
        int n5;
        int busy;

        n_RES = 1'b1; n_NMI = 1'b1; n_IRQ = 1'b1; I_FLAG = 1'b1;
        BRK_REQ = 1'b0; SYNC = 1'b0; RDY = 1'b1;
        DEC_ADL_ABL = 1'b1; DEC_ADH_ABH = 1'b1;

        // Reset: outputs forced with no clock edge, passthrough gated off
        #1 n_RES = 1'b0;
        #1 check("rst_async", obs, E_RST);
        repeat (3) step("rst_hold", E_RST);
        n_RES = 1'b1; DEC_ADL_ABL = 1'b0; DEC_ADH_ABH = 1'b0;
        step("res_t1", R_T1);
        step("res_t2", R_PU);
        step("res_t3", R_PU);
        step("res_t4", R_PU);
        step("res_t5", R_T5);
        step("res_t6", R_T6);
        DEC_ADL_ABL = 1'b1;
        step("res_idle_pass", 10'b0_1_0_000_0_0_0_0);

        // IRQ masked: no entry, passthrough follows decoder
        n_IRQ = 1'b0; SYNC = 1'b1; DEC_ADL_ABL = 1'b0; DEC_ADH_ABH = 1'b1;
        step("irq_masked", 10'b0_0_1_000_0_0_0_0);
        step("irq_masked2", 10'b0_0_1_000_0_0_0_0);

        // IRQ unmasked
        I_FLAG = 1'b0;
        step("irq_t1", I_T1);
        n_IRQ = 1'b1; SYNC = 1'b0; DEC_ADH_ABH = 1'b0;
        step("irq_t2", I_PU);
        step("irq_t3", I_PU);
        step("irq_t4", I_PU);
        step("irq_t5", I_T5);
        step("irq_t6", I_T6);
        step("irq_idle", E_IDLE);

        // RDY: ignored in T2..T4, holds T5
        n_IRQ = 1'b0; SYNC = 1'b1;
        step("rdy_t1", I_T1);
        n_IRQ = 1'b1; SYNC = 1'b0;
        step("rdy_t2", I_PU);
        RDY = 1'b0;
        step("rdy_t3", I_PU);
        step("rdy_t4", I_PU);
        step("rdy_t5", I_T5);
        step("rdy_hold1", I_T5);
        step("rdy_hold2", I_T5);
        RDY = 1'b1;
        step("rdy_t6", I_T6);
        step("rdy_idle", E_IDLE);

        // BRK and IRQ together: IRQ wins, BRK dropped
        n_IRQ = 1'b0; BRK_REQ = 1'b1; SYNC = 1'b1;
        step("brkirq_t1", I_T1);
        n_IRQ = 1'b1; BRK_REQ = 1'b0; SYNC = 1'b0;
        step("brkirq_t2", I_PU);
        step("brkirq_t3", I_PU);
        step("brkirq_t4", I_PU);
        step("brkirq_t5", I_T5);
        step("brkirq_t6", I_T6);
        SYNC = 1'b1;
        step("brkirq_idle", E_IDLE);
        step("brk_dropped", E_IDLE);

        // BRK with NMI hijack during T3
        I_FLAG = 1'b1; BRK_REQ = 1'b1;
        step("brk_t1", B_T1);
        BRK_REQ = 1'b0; SYNC = 1'b0;
        step("brk_t2", B_PU);
        step("brk_t3", B_PU);
        n_NMI = 1'b0;
        step("hij_t4", B_PU);
        step("hij_t5", BN_T5);
        step("hij_t6", BN_T6);
        SYNC = 1'b1;
        step("hij_idle", E_IDLE);
        step("nmi_cleared", E_IDLE);
        n_NMI = 1'b1; SYNC = 1'b0;
        tick();

        // NMI held low for 10 edges: exactly one sequence
        SYNC = 1'b1; n_NMI = 1'b0;
        n5 = 0; busy = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (obs === N_T5) n5++;
            if (SEQ_BUSY === 1'b1) busy++;
        end
        check("nmi_lvl_seqs", 10'(n5), 10'd1);
        check("nmi_lvl_busy", 10'(busy), 10'd6);
        check("nmi_lvl_idle", obs, E_IDLE);
        n_NMI = 1'b1; SYNC = 1'b0;
        tick();

        // Reset abort in T4 of an IRQ sequence
        I_FLAG = 1'b0; n_IRQ = 1'b0; SYNC = 1'b1;
        step("abort_t1", I_T1);
        n_IRQ = 1'b1; SYNC = 1'b0;
        step("abort_t2", I_PU);
        step("abort_t3", I_PU);
        step("abort_t4", I_PU);
        #2 n_RES = 1'b0; DEC_ADL_ABL = 1'b1;
        #1 check("abort_async", obs, E_RST);
        step("abort_hold", E_RST);
        n_RES = 1'b1; DEC_ADL_ABL = 1'b0;
        step("abort_res_t1", R_T1);
        step("abort_res_t2", R_PU);
        step("abort_res_t3", R_PU);
        step("abort_res_t4", R_PU);
        step("abort_res_t5", R_T5);

        // NMI edge in T5: latch kept, served at next SYNC
        n_NMI = 1'b0;
        step("late_res_t6", R_T6);
        step("late_idle", E_IDLE);
        SYNC = 1'b1;
        step("late_nmi_t1", I_T1);
        SYNC = 1'b0;
        step("late_nmi_t2", I_PU);
        step("late_nmi_t3", I_PU);
        step("late_nmi_t4", I_PU);
        step("late_nmi_t5", N_T5);
        step("late_nmi_t6", N_T6);
        step("late_nmi_idle", E_IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/abus_vector_seq.md
# abus_vector_seq

Address-bus sequencer for the 6502 core's interrupt and reset entry. It owns the ABL/ABH load enables, which drive the `ADX_ABX` inputs of the address-bus bit cells, and the `Z_ADL0..2` vector-zeroing strobes. It arbitrates four sources (RES, NMI, IRQ, BRK) and runs the 7-cycle stack-push and vector-fetch sequence. When idle it passes the decoder's load enables straight through.

## Interface
No parameters.

- `PHI0` in 1: single core clock; all state updates on the rising edge.
- `n_RES` in 1: reset, asynchronous, active-low.
- `n_NMI` in 1: NMI pin, active-low, falling-edge sensitive.
- `n_IRQ` in 1: IRQ pin, active-low, level sensitive.
- `I_FLAG` in 1: interrupt-disable flag from the P register.
- `BRK_REQ` in 1: decoder strobe, high for the cycle after a BRK opcode fetch.
- `SYNC` in 1: opcode-fetch cycle, i.e. the instruction boundary.
- `RDY` in 1: low stalls the sequencer on read cycles.
- `DEC_ADL_ABL` in 1: decoder's request to load ABL.
- `DEC_ADH_ABH` in 1: decoder's request to load ABH.
- `ADL_ABL` out 1: ABL load enable to the low address-bus bits.
- `ADH_ABH` out 1: ABH load enable to the high address-bus bits.
- `Z_ADL0`, `Z_ADL1`, `Z_ADL2` out 1 each: force ADL bit 0, 1 or 2 to zero.
- `VEC_FETCH` out 1: high during the vector-read cycles.
- `STACK_PUSH` out 1: high during the PCH, PCL and P push cycles.
- `RW_SUPPRESS` out 1: converts push writes to reads (reset sequence only).
- `B_OUT` out 1: value of the B bit for the P push.
- `SEQ_BUSY` out 1: sequencer not in IDLE.

## Operation
- States: RES_HOLD, IDLE, T1 (dummy read), T2 (push PCH), T3 (push PCL), T4 (push P), T5 (vector low), T6 (vector high).
- Active source is latched on entry to T1 as one of RES, NMI, IRQ, BRK.
- Entry conditions:
  - RES_HOLD → T1 on the first edge with `n_RES` high; source = RES.
  - IDLE → T1 on an edge where `SYNC`=1 and a request is pending.
  - Priority: NMI latch > IRQ (`n_IRQ`=0 and `I_FLAG`=0) > `BRK_REQ`.
- NMI latch:
  - Set by a falling edge on `n_NMI`, sampled at `PHI0`.
  - Cleared on entering T5 with vector NMI.
  - A second edge while the latch is set is absorbed.
- NMI hijack: if the NMI latch sets while the source is IRQ or BRK, in any of T1..T4, the T5/T6 vector becomes NMI. `B_OUT` keeps the original source's value.
- The T1..T6 sequence advances one state per edge; T6 → IDLE.
- Outputs are Moore decodes of state and source:
  - T1..T6: `ADL_ABL`=`ADH_ABH`=1. Otherwise `ADL_ABL`=`DEC_ADL_ABL` and `ADH_ABH`=`DEC_ADH_ABH`.
  - T5 strobes: `Z_ADL0`=1 for all sources; plus `Z_ADL2`=1 for NMI (FFFA), `Z_ADL1`=1 for RES (FFFC), neither for IRQ/BRK (FFFE).
  - T6: the same `Z_ADL1`/`Z_ADL2` pattern as T5, with `Z_ADL0`=0 (FFFB/FFFD/FFFF).
  - `VEC_FETCH`=1 in T5 and T6.
  - `STACK_PUSH`=1 in T2..T4.
  - `RW_SUPPRESS`=1 in T2..T4 when source = RES.
  - `B_OUT`=1 only when source = BRK.
- `RDY`=0 holds the state in IDLE, T1, T5 and T6. It is ignored in T2..T4, which are write cycles.

## Timing
- While `n_RES`=0, immediately and independent of `PHI0`:
  - state = RES_HOLD; NMI latch and source cleared.
  - `SEQ_BUSY`=1, `RW_SUPPRESS`=1; all other outputs 0, including the passthrough.
- Reset mid-sequence aborts to RES_HOLD at once.
- Latency:
  - `SYNC` plus pending request at edge N → T1 visible after edge N; first vector read (T5) after edge N+4.
  - Reset release → T5 after the 5th edge.
- Simultaneous events:
  - `BRK_REQ` and IRQ together: IRQ wins; BRK is dropped, because the decoder re-fetches the opcode.
  - NMI edge arriving in T5 or T6: the latch stays set and is served at the next `SYNC`.

## Structure
- Package `abus_seq_pkg` holds:
  - the state enum;
  - the source enum (SRC_RES, SRC_NMI, SRC_IRQ, SRC_BRK);
  - the 3-bit `Z_ADL` patterns per vector.
- Sub-module `nmi_edge_det`: `n_NMI` sample flop, falling-edge detect, latch with a clear input. Asynchronous `n_RES` clear.

## Test plan
- Reset: hold `n_RES`=0 for 3 edges, then release. Expect T1..T6 on consecutive edges, `RW_SUPPRESS`=1 in T2..T4, `Z_ADL`=3'b011 in T5 and 3'b010 in T6 (bit order Z_ADL2..0), then IDLE.
- IRQ: `I_FLAG`=0, `n_IRQ`=0 at `SYNC` → vector FFFE/FFFF (`Z_ADL`=001 then 000), `B_OUT`=0. Repeat with `I_FLAG`=1 → no entry, decoder passthrough preserved.
- BRK plus NMI hijack: `BRK_REQ`, then an `n_NMI` fall during T3 → `B_OUT`=1 through T4, T5 `Z_ADL`=101, NMI latch cleared at T5.
- RDY stall: `RDY`=0 for 2 edges in T5 → state held, `VEC_FETCH` stays 1. `RDY`=0 in T3 → T4 follows anyway.
- Reset abort: drop `n_RES` in T4 of an IRQ sequence → outputs reach reset values with no `PHI0` edge. On release, the RES vector is used.
- NMI edge vs level: hold `n_NMI` low for 10 edges → exactly one NMI sequence.
